// File: rtl/ff_pkg.sv
// Mode encoding shared by the universal shift register, its fill counter and benches.
package ff_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_SHR  = 2'b11
  } mode_e;

endpackage

// File: rtl/ff_fill_cnt.sv
// Saturating count of valid bits shifted in since the last clear or parallel load.
module ff_fill_cnt #(
  parameter  int WIDTH = 8,
  localparam int FW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic          load,
  input  logic          inc,
  output logic [FW-1:0] fill,
  output logic          full
);

  localparam logic [FW-1:0] FILL_MAX = FW'(WIDTH);

  logic [FW-1:0] fill_q;
  logic [FW-1:0] fill_d;

  always_comb begin
    fill_d = fill_q;
    if (en) begin
      if (load) begin
        fill_d = FILL_MAX;
      end else if (inc && (fill_q != FILL_MAX)) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign fill = fill_q;
  assign full = (fill_q == FILL_MAX);

endmodule

// File: rtl/ff_shift_reg.sv
// WIDTH-bit universal register: hold, parallel load, shift left/right with optional rotate.
module ff_shift_reg
  import ff_pkg::*;
#(
  parameter  int               WIDTH     = 8,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int               FW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             rot,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [FW-1:0]    fill,
  output logic             full
);

  if (WIDTH < 2) begin : g_width_check
    $error("ff_shift_reg: WIDTH must be >= 2");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             shift;
  logic             load;
  logic             inc;

  always_comb begin
    q_d = q_q;
    if (en) begin
      unique case (mode_e'(mode))
        MODE_HOLD: q_d = q_q;
        MODE_LOAD: q_d = d;
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], (rot ? q_q[WIDTH-1] : sin)};
        MODE_SHR:  q_d = {(rot ? q_q[0] : sin), q_q[WIDTH-1:1]};
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  // Rotations recirculate existing bits, so only serial-in shifts add to fill.
  assign shift = mode[1];
  assign load  = (mode == MODE_LOAD);
  assign inc   = shift & ~rot;

  ff_fill_cnt #(
    .WIDTH (WIDTH)
  ) u_fill_cnt (
    .clk  (clk),
    .clr  (clr),
    .en   (en),
    .load (load),
    .inc  (inc),
    .fill (fill),
    .full (full)
  );

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];

endmodule
